ex_mdu: RTL and testbench
=========================

Name: ex_mdu

Overview:
- Parametrised next-generation execute stage. Covers the existing single-cycle logic/arith/shift ALU ops and adds iterative multiply/divide (RV32M semantics).
- Registered outputs with valid/ready handshakes on both sides, so the pipeline stalls on multi-cycle ops.
- Sits between the id_ex pipeline register and ex_mem; ex_mem back-pressures through out_ready.

Parameters:
- XLEN, 32, datapath width; must be a power of two, ≥ 8.
- SHW, $clog2(XLEN), shift-amount width taken from opv2[SHW-1:0].
- ADDR_W, 5, register address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset, sampled on the rising edge of clk).
- flush  in  1  kill the in-flight op; takes priority over all handshakes.
- in_valid  in  1  operation presented.
- in_ready  out  1  unit can accept an operation this cycle.
- alusel  in  `AluSelBus  result class: LOGIC, ARITH, SHIFT, MUL, DIV.
- aluop  in  `AluOpBus  op within the class.
- opv1, opv2  in  XLEN  operands.
- waddr_i  in  ADDR_W  destination register.
- we_i  in  1  write enable.
- out_valid  out  1  result held on the outputs.
- out_ready  in  1  downstream consumed the result.
- waddr_o  out  ADDR_W  registered copy of waddr_i.
- we_o  out  1  registered copy of we_i.
- wdata  out  XLEN  result.

Behaviour:
- Encodings: from the shared defines header. New entries EXE_RES_MUL, EXE_RES_DIV, MUL/MULH/MULHSU/MULHU_OP and DIV/DIVU/REM/REMU_OP are added there.
- Reset (rst=0 at an edge): state=IDLE, out_valid=0, waddr_o=0, we_o=0, wdata=0, internal counter and accumulators=0. Reset mid-operation abandons the op; no output is produced.
- in_ready = (state==IDLE) || (state==DONE && out_ready), combinational. Must be 0 during BUSY and while flush=1.
- Accept when in_valid && in_ready at an edge. Operands, aluop, alusel, waddr_i and we_i are latched.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, accept of LOGIC/ARITH/SHIFT -> DONE, with the result computed combinationally and registered (latency 1).
  - IDLE, accept of MUL/DIV -> BUSY, counter=0.
  - IDLE, no accept -> IDLE.
  - BUSY: one iteration per cycle. After the XLEN-th iteration -> DONE, result registered (latency XLEN+1 cycles from accept to out_valid).
  - DONE: out_valid=1. Outputs hold stable while out_ready=0.
  - DONE with out_ready=1: -> IDLE if no new accept. If a new op is accepted in the same cycle, take the IDLE accept transition directly (back-to-back, no bubble).
- Unknown alusel/aluop: accepted; completes with latency 1, wdata=0, we_o passes through.
- Single-cycle ops:
  - XOR/OR/AND, ADD/SUB (mod 2^XLEN).
  - SLT signed, SLTU unsigned; result is 1 or 0, zero-extended.
  - SLL/SRL/SRA by opv2[SHW-1:0]; SRA sign-fills.
- Multiply: radix-2 shift-add over a 2·XLEN product.
  - Operand signedness: MULH signed×signed, MULHSU signed×unsigned, MULHU unsigned×unsigned.
  - Signed operands are converted to magnitudes, and the result sign is corrected at the end.
  - MUL returns the low XLEN bits; MULH* return the high XLEN bits.
- Divide: restoring, one quotient bit per cycle, on magnitudes with a final sign fix.
  - Quotient sign = sign(opv1)^sign(opv2). Remainder sign = sign(opv1).
  - Divide by zero: quotient = all ones, remainder = opv1 (still takes XLEN+1 cycles).
  - Signed overflow (opv1 = most-negative, opv2 = −1): DIV = most-negative, REM = 0.
- flush=1 at an edge: state -> IDLE, out_valid=0 next cycle. Any accept attempted in that same cycle is ignored. waddr_o, we_o and wdata hold their last values. flush while rst=0 has no extra effect.
- waddr_o, we_o and wdata change only on the transition into DONE, or on reset.

Test Plan:
- Reset: hold rst=0 for 2 cycles with in_valid=1 -> out_valid=0, wdata=0, we_o=0, in_ready=1 after release.
- Single-cycle ADD 0xFFFFFFFF+1, then SRA 0x80000000 by 4, issued back-to-back with out_ready=1 -> wdata 0x00000000 then 0xF8000000, out_valid every cycle, no bubble.
- MULH −2 × 3 and MULHU 0xFFFFFFFF × 0xFFFFFFFF (XLEN=32):
  - out_valid rises exactly 33 cycles after accept.
  - wdata = 0xFFFFFFFF, then 0xFFFFFFFE.
  - in_ready=0 throughout BUSY.
- Divide corners:
  - DIV 7 / 0 -> 0xFFFFFFFF; REMU 7 / 0 -> 7.
  - DIV 0x80000000 / −1 -> 0x80000000; REM 0x80000000 / −1 -> 0.
  - REM −7 / 2 -> 0xFFFFFFFF (−1).
- Back-pressure and flush:
  - Hold out_ready=0 for 5 cycles after DIVU 100/7 completes -> wdata=14 stays stable, in_ready=0.
  - Separately, assert flush mid-BUSY at cycle 10 -> out_valid never rises, IDLE next cycle, next op accepted normally.
- XLEN=16 build: MUL 0x8000×2 -> 0x0000, latency 17; SLL by opv2=0x0013 uses shamt 3.

Source files
------------

// File: rtl/ex_mdu.sv
// ex_mdu: execute stage with single-cycle logic/arith/shift ops and iterative
// RV32M-style multiply/divide, valid/ready handshaked on both sides.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-low reset
//   flush      kill any in-flight or held op; overrides handshakes
//   in_valid   op presented       / in_ready  op can be taken (combinational)
//   alusel     result class       / aluop     op within the class
//   opv1, opv2 operands
//   waddr_i    destination reg    / we_i      write enable
//   out_valid  result valid       / out_ready downstream takes result
//   waddr_o, we_o, wdata          registered result fields

package ex_mdu_pkg;
    localparam int unsigned SEL_W = 3;
    localparam int unsigned OP_W  = 4;

    // Result classes; any other alusel value is treated as an unknown op.
    localparam logic [SEL_W-1:0] EXE_RES_LOGIC = 3'd1;
    localparam logic [SEL_W-1:0] EXE_RES_ARITH = 3'd2;
    localparam logic [SEL_W-1:0] EXE_RES_SHIFT = 3'd3;
    localparam logic [SEL_W-1:0] EXE_RES_MUL   = 3'd4;
    localparam logic [SEL_W-1:0] EXE_RES_DIV   = 3'd5;

    localparam logic [OP_W-1:0] XOR_OP    = 4'd0;
    localparam logic [OP_W-1:0] OR_OP     = 4'd1;
    localparam logic [OP_W-1:0] AND_OP    = 4'd2;

    localparam logic [OP_W-1:0] ADD_OP    = 4'd0;
    localparam logic [OP_W-1:0] SUB_OP    = 4'd1;
    localparam logic [OP_W-1:0] SLT_OP    = 4'd2;
    localparam logic [OP_W-1:0] SLTU_OP   = 4'd3;

    localparam logic [OP_W-1:0] SLL_OP    = 4'd0;
    localparam logic [OP_W-1:0] SRL_OP    = 4'd1;
    localparam logic [OP_W-1:0] SRA_OP    = 4'd2;

    localparam logic [OP_W-1:0] MUL_OP    = 4'd0;
    localparam logic [OP_W-1:0] MULH_OP   = 4'd1;
    localparam logic [OP_W-1:0] MULHSU_OP = 4'd2;
    localparam logic [OP_W-1:0] MULHU_OP  = 4'd3;

    localparam logic [OP_W-1:0] DIV_OP    = 4'd0;
    localparam logic [OP_W-1:0] DIVU_OP   = 4'd1;
    localparam logic [OP_W-1:0] REM_OP    = 4'd2;
    localparam logic [OP_W-1:0] REMU_OP   = 4'd3;
endpackage

module ex_mdu
    import ex_mdu_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned SHW    = $clog2(XLEN),
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SEL_W-1:0]  alusel,
    input  logic [OP_W-1:0]   aluop,
    input  logic [XLEN-1:0]   opv1,
    input  logic [XLEN-1:0]   opv2,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic              we_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] waddr_o,
    output logic              we_o,
    output logic [XLEN-1:0]   wdata
);

    localparam int unsigned XW2 = 2 * XLEN;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [SHW-1:0]      r_cnt;
    logic [XW2-1:0]      r_acc;     // mul: {partial product, multiplier}; div: {remainder, quotient}
    logic [XLEN-1:0]     r_mag;     // mul: |multiplicand|; div: |divisor|
    logic                r_is_div;
    logic                r_sel_hi;  // mul: take high half; div: take remainder
    logic                r_neg;     // negate the selected magnitude result
    logic [ADDR_W-1:0]   r_waddr;
    logic                r_we;

    logic                w_accept;
    logic [SHW-1:0]      w_shamt;
    logic [XLEN-1:0]     w_alu_res;
    logic                w_is_mul;
    logic                w_is_div;
    logic                w_sgn_a;
    logic                w_sgn_b;
    logic                w_neg_a;
    logic                w_neg_b;
    logic [XLEN-1:0]     w_mag_a;
    logic [XLEN-1:0]     w_mag_b;
    logic                w_res_neg;
    logic [XLEN:0]       w_mul_sum;
    logic [XW2-1:0]      w_mul_acc;
    logic [XLEN:0]       w_div_sh;
    logic                w_div_ge;
    logic [XLEN-1:0]     w_div_diff;
    logic [XW2-1:0]      w_div_acc;
    logic [XW2-1:0]      w_prod_s;
    logic [XLEN-1:0]     w_mul_res;
    logic [XLEN-1:0]     w_div_pick;
    logic [XLEN-1:0]     w_div_res;
    logic [XLEN-1:0]     w_final;

    // Accept handshake; flush blocks any accept in its cycle.
    assign in_ready = ((r_state == S_IDLE) || ((r_state == S_DONE) && out_ready)) && !flush;
    assign w_accept = in_valid && in_ready;
    assign w_shamt  = opv2[SHW-1:0];

    // Single-cycle result; unknown class/op yields zero.
    always_comb begin
        w_alu_res = '0;
        case (alusel)
            EXE_RES_LOGIC: begin
                case (aluop)
                    XOR_OP:  w_alu_res = opv1 ^ opv2;
                    OR_OP:   w_alu_res = opv1 | opv2;
                    AND_OP:  w_alu_res = opv1 & opv2;
                    default: w_alu_res = '0;
                endcase
            end
            EXE_RES_ARITH: begin
                case (aluop)
                    ADD_OP:  w_alu_res = opv1 + opv2;
                    SUB_OP:  w_alu_res = opv1 - opv2;
                    SLT_OP:  w_alu_res = XLEN'($signed(opv1) < $signed(opv2));
                    SLTU_OP: w_alu_res = XLEN'(opv1 < opv2);
                    default: w_alu_res = '0;
                endcase
            end
            EXE_RES_SHIFT: begin
                case (aluop)
                    SLL_OP:  w_alu_res = opv1 << w_shamt;
                    SRL_OP:  w_alu_res = opv1 >> w_shamt;
                    SRA_OP:  w_alu_res = XLEN'($signed(opv1) >>> w_shamt);
                    default: w_alu_res = '0;
                endcase
            end
            default: w_alu_res = '0;
        endcase
    end

    // Multi-cycle decode: operand signedness and the final sign correction.
    assign w_is_mul  = (alusel == EXE_RES_MUL) && (aluop <= MULHU_OP);
    assign w_is_div  = (alusel == EXE_RES_DIV) && (aluop <= REMU_OP);
    assign w_sgn_a   = (w_is_mul && ((aluop == MULH_OP) || (aluop == MULHSU_OP)))
                     || (w_is_div && ((aluop == DIV_OP) || (aluop == REM_OP)));
    assign w_sgn_b   = (w_is_mul && (aluop == MULH_OP))
                     || (w_is_div && ((aluop == DIV_OP) || (aluop == REM_OP)));
    assign w_neg_a   = w_sgn_a && opv1[XLEN-1];
    assign w_neg_b   = w_sgn_b && opv2[XLEN-1];
    assign w_mag_a   = w_neg_a ? -opv1 : opv1;
    assign w_mag_b   = w_neg_b ? -opv2 : opv2;
    // Divide by zero leaves the all-ones magnitude quotient unsigned.
    assign w_res_neg = w_is_mul             ? (w_neg_a ^ w_neg_b) :
                       (aluop == DIV_OP)    ? ((w_neg_a ^ w_neg_b) && (opv2 != '0)) :
                       (aluop == REM_OP)    ? w_neg_a : 1'b0;

    // Shift-add step: add multiplicand into the high half when the LSB is set.
    assign w_mul_sum = {1'b0, r_acc[XW2-1:XLEN]} + (r_acc[0] ? {1'b0, r_mag} : '0);
    assign w_mul_acc = {w_mul_sum, r_acc[XLEN-1:1]};

    // Restoring step: shift in the next dividend bit, subtract if it fits.
    assign w_div_sh   = {r_acc[XW2-1:XLEN], r_acc[XLEN-1]};
    assign w_div_ge   = w_div_sh >= {1'b0, r_mag};
    assign w_div_diff = w_div_sh[XLEN-1:0] - r_mag;
    assign w_div_acc  = w_div_ge ? {w_div_diff,         r_acc[XLEN-2:0], 1'b1}
                                 : {w_div_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};

    // Final result from the last iteration's next value.
    assign w_prod_s   = r_neg ? -w_mul_acc : w_mul_acc;
    assign w_mul_res  = r_sel_hi ? w_prod_s[XW2-1:XLEN] : w_prod_s[XLEN-1:0];
    assign w_div_pick = r_sel_hi ? w_div_acc[XW2-1:XLEN] : w_div_acc[XLEN-1:0];
    assign w_div_res  = r_neg ? -w_div_pick : w_div_pick;
    assign w_final    = r_is_div ? w_div_res : w_mul_res;

    // Control FSM and all registered state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_mag     <= '0;
            r_is_div  <= 1'b0;
            r_sel_hi  <= 1'b0;
            r_neg     <= 1'b0;
            r_waddr   <= '0;
            r_we      <= 1'b0;
            out_valid <= 1'b0;
            waddr_o   <= '0;
            we_o      <= 1'b0;
            wdata     <= '0;
        end else if (flush) begin
            r_state   <= S_IDLE;
            out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        if (w_is_mul || w_is_div) begin
                            r_state   <= S_BUSY;
                            out_valid <= 1'b0;
                            r_cnt     <= '0;
                            r_is_div  <= w_is_div;
                            r_sel_hi  <= w_is_mul ? (aluop != MUL_OP)
                                                  : ((aluop == REM_OP) || (aluop == REMU_OP));
                            r_neg     <= w_res_neg;
                            r_mag     <= w_is_div ? w_mag_b : w_mag_a;
                            r_acc     <= {{XLEN{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
                            r_waddr   <= waddr_i;
                            r_we      <= we_i;
                        end else begin
                            r_state   <= S_DONE;
                            out_valid <= 1'b1;
                            wdata     <= w_alu_res;
                            waddr_o   <= waddr_i;
                            we_o      <= we_i;
                        end
                    end else if ((r_state == S_DONE) && out_ready) begin
                        r_state   <= S_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                S_BUSY: begin
                    r_acc <= r_is_div ? w_div_acc : w_mul_acc;
                    r_cnt <= r_cnt + SHW'(1);
                    if (r_cnt == SHW'(XLEN - 1)) begin
                        r_state   <= S_DONE;
                        out_valid <= 1'b1;
                        wdata     <= w_final;
                        waddr_o   <= r_waddr;
                        we_o      <= r_we;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_mdu.sv
// tb_ex_mdu: randomized scoreboard bench for ex_mdu (XLEN=32) plus a small
// directed/random pass over an XLEN=16 instance.
//
// Ports: none (top-level bench).

module tb_ex_mdu;
    import ex_mdu_pkg::*;

    localparam int unsigned XL = 32;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready, we_i, we_o;
    logic [2:0]  alusel;
    logic [3:0]  aluop;
    logic [31:0] opv1, opv2, wdata;
    logic [4:0]  waddr_i, waddr_o;

    logic        in_valid16, in_ready16, out_valid16, we_o16;
    logic [2:0]  alusel16;
    logic [3:0]  aluop16;
    logic [15:0] opv1_16, opv2_16, wdata16;
    logic [4:0]  waddr_o16;

    always #5 clk = ~clk;

    ex_mdu #(.XLEN(32)) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .alusel(alusel), .aluop(aluop), .opv1(opv1), .opv2(opv2),
        .waddr_i(waddr_i), .we_i(we_i),
        .out_valid(out_valid), .out_ready(out_ready),
        .waddr_o(waddr_o), .we_o(we_o), .wdata(wdata)
    );

    ex_mdu #(.XLEN(16)) u_dut16 (
        .clk(clk), .rst(rst), .flush(1'b0),
        .in_valid(in_valid16), .in_ready(in_ready16),
        .alusel(alusel16), .aluop(aluop16), .opv1(opv1_16), .opv2(opv2_16),
        .waddr_i(5'd3), .we_i(1'b1),
        .out_valid(out_valid16), .out_ready(1'b1),
        .waddr_o(waddr_o16), .we_o(we_o16), .wdata(wdata16)
    );

    typedef struct {
        logic [31:0] data;
        logic [4:0]  waddr;
        logic        we;
        int          acc_cyc;
        int          lat;
    } exp_t;

    exp_t q[$];
    int   total    = 0;
    int   bad      = 0;
    int   cyc      = 0;
    int   busy_end = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic bit is_multi(input logic [2:0] sel, input logic [3:0] op);
        return ((sel == EXE_RES_MUL) || (sel == EXE_RES_DIV)) && (op <= 4'd3);
    endfunction

    function automatic int exp_lat(input logic [2:0] sel, input logic [3:0] op, input int w);
        return is_multi(sel, op) ? w + 1 : 1;
    endfunction

    // Reference result from plain integer arithmetic at width w.
    function automatic logic [31:0] model(input logic [2:0] sel, input logic [3:0] op,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input int w);
        longint unsigned mask, ua, ub, r;
        longint          sa, sb, most_neg;
        int              sh;
        mask     = (longint'(1) << w) - 1;
        ua       = longint'(a) & mask;
        ub       = longint'(b) & mask;
        sa       = a[w-1] ? longint'(ua) - (longint'(1) << w) : longint'(ua);
        sb       = b[w-1] ? longint'(ub) - (longint'(1) << w) : longint'(ub);
        most_neg = -(longint'(1) << (w - 1));
        sh       = int'(ub % longint'(w));
        r        = 0;
        case (sel)
            EXE_RES_LOGIC: case (op)
                XOR_OP: r = ua ^ ub;
                OR_OP:  r = ua | ub;
                AND_OP: r = ua & ub;
                default: r = 0;
            endcase
            EXE_RES_ARITH: case (op)
                ADD_OP:  r = ua + ub;
                SUB_OP:  r = ua - ub;
                SLT_OP:  r = (sa < sb) ? 1 : 0;
                SLTU_OP: r = (ua < ub) ? 1 : 0;
                default: r = 0;
            endcase
            EXE_RES_SHIFT: case (op)
                SLL_OP: r = ua << sh;
                SRL_OP: r = ua >> sh;
                SRA_OP: r = sa >>> sh;
                default: r = 0;
            endcase
            EXE_RES_MUL: case (op)
                MUL_OP:    r = ua * ub;
                MULH_OP:   r = (sa * sb) >>> w;
                MULHSU_OP: r = (sa * longint'(ub)) >>> w;
                MULHU_OP:  r = (ua * ub) >> w;
                default:   r = 0;
            endcase
            EXE_RES_DIV: case (op)
                DIV_OP:  r = (sb == 0) ? -1 : ((sa == most_neg) && (sb == -1)) ? sa : sa / sb;
                DIVU_OP: r = (ub == 0) ? mask : ua / ub;
                REM_OP:  r = (sb == 0) ? sa : ((sa == most_neg) && (sb == -1)) ? 0 : sa % sb;
                REMU_OP: r = (ub == 0) ? ua : ua % ub;
                default: r = 0;
            endcase
            default: r = 0;
        endcase
        return 32'(r & mask);
    endfunction

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            4: return -32'($urandom_range(1, 15));
            default: return $urandom;
        endcase
    endfunction

    // Present one op (starting at a negedge) until accepted; push its expectation.
    task automatic send(input logic [2:0] sel, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b, input bit rnd_ready);
        exp_t e;
        bit   done = 0;
        alusel   = sel;
        aluop    = op;
        opv1     = a;
        opv2     = b;
        waddr_i  = 5'($urandom);
        we_i     = 1'($urandom);
        in_valid = 1'b1;
        for (int t = 0; t < 100 && !done; t++) begin
            out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            if (cyc < busy_end) chk("in_ready_busy", 64'(in_ready), 64'(0));
            if (in_ready) begin
                e.data    = model(sel, op, a, b, XL);
                e.waddr   = waddr_i;
                e.we      = we_i;
                e.acc_cyc = cyc + 1;
                e.lat     = exp_lat(sel, op, XL);
                q.push_back(e);
                busy_end  = is_multi(sel, op) ? cyc + 1 + XL : 0;
                done      = 1;
            end
            @(posedge clk);
            @(negedge clk);
        end
        chk("accept", 64'(done), 64'(1));
    endtask

    task automatic idle(input int n, input bit rnd_ready);
        in_valid = 1'b0;
        repeat (n) begin
            out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int t = 0; t < 200 && (q.size() != 0 || out_valid); t++) begin
            out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        chk("drain", 64'(q.size()), 64'(0));
    endtask

    // Scoreboard monitor: compares each new result presented by the DUT.
    logic        held = 1'b0;
    logic [31:0] h_d;
    logic [4:0]  h_a;
    logic        h_w;
    always @(negedge clk) begin : mon
        exp_t e;
        #2;
        if (rst && out_valid) begin
            if (held) begin
                chk("hold_wdata", 64'(wdata), 64'(h_d));
                chk("hold_waddr", 64'(waddr_o), 64'(h_a));
                chk("hold_we", 64'(we_o), 64'(h_w));
            end else if (q.size() == 0) begin
                chk("unexpected_out", 64'(out_valid), 64'(0));
            end else begin
                e = q.pop_front();
                chk("wdata", 64'(wdata), 64'(e.data));
                chk("waddr_o", 64'(waddr_o), 64'(e.waddr));
                chk("we_o", 64'(we_o), 64'(e.we));
                chk("latency", 64'(cyc - e.acc_cyc + 1), 64'(e.lat));
            end
            held = !out_ready;
            h_d  = wdata;
            h_a  = waddr_o;
            h_w  = we_o;
        end else begin
            held = 1'b0;
        end
    end

    // One op on the XLEN=16 instance with latency and result check.
    task automatic run16(input logic [2:0] sel, input logic [3:0] op,
                         input logic [15:0] a, input logic [15:0] b);
        logic [31:0] ref32;
        int          lat  = 0;
        bit          seen = 0;
        ref32      = model(sel, op, 32'(a), 32'(b), 16);
        alusel16   = sel;
        aluop16    = op;
        opv1_16    = a;
        opv2_16    = b;
        in_valid16 = 1'b1;
        #1;
        chk("in_ready16", 64'(in_ready16), 64'(1));
        @(posedge clk);
        @(negedge clk);
        in_valid16 = 1'b0;
        for (int t = 1; t <= 40 && !seen; t++) begin
            #2;
            if (out_valid16) begin
                seen = 1;
                lat  = t;
            end else begin
                @(posedge clk);
                @(negedge clk);
            end
        end
        chk("lat16", 64'(lat), 64'(exp_lat(sel, op, 16)));
        chk("wdata16", 64'(wdata16), 64'(ref32[15:0]));
        chk("waddr16", 64'(waddr_o16), 64'(3));
        chk("we16", 64'(we_o16), 64'(1));
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b0;
        flush      = 1'b0;
        in_valid   = 1'b1;
        out_ready  = 1'b1;
        alusel     = EXE_RES_ARITH;
        aluop      = ADD_OP;
        opv1       = 32'h1234_5678;
        opv2       = 32'h1111_1111;
        waddr_i    = 5'd7;
        we_i       = 1'b1;
        in_valid16 = 1'b0;
        alusel16   = '0;
        aluop16    = '0;
        opv1_16    = '0;
        opv2_16    = '0;

        // Reset held for two edges with an op offered.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_wdata", 64'(wdata), 64'(0));
        chk("rst_we_o", 64'(we_o), 64'(0));
        chk("rst_waddr_o", 64'(waddr_o), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        @(negedge clk);

        // Back-to-back single-cycle ops.
        send(EXE_RES_ARITH, ADD_OP, 32'hFFFF_FFFF, 32'h1, 0);
        send(EXE_RES_SHIFT, SRA_OP, 32'h8000_0000, 32'h4, 0);
        idle(2, 0);

        // Multiplies: high halves, latency, busy in_ready.
        send(EXE_RES_MUL, MULH_OP, 32'hFFFF_FFFE, 32'h3, 0);
        send(EXE_RES_MUL, MULHU_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        drain();

        // Divide corners.
        send(EXE_RES_DIV, DIV_OP, 32'h7, 32'h0, 0);
        send(EXE_RES_DIV, REMU_OP, 32'h7, 32'h0, 0);
        send(EXE_RES_DIV, DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        send(EXE_RES_DIV, REM_OP, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        send(EXE_RES_DIV, REM_OP, 32'hFFFF_FFF9, 32'h2, 0);
        drain();

        // Back-pressure: DIVU 100/7 held for five cycles.
        send(EXE_RES_DIV, DIVU_OP, 32'd100, 32'd7, 0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int t = 0; t < 40 && !out_valid; t++) begin
            @(posedge clk);
            @(negedge clk);
        end
        for (int t = 0; t < 5; t++) begin
            #1;
            chk("bp_out_valid", 64'(out_valid), 64'(1));
            chk("bp_in_ready", 64'(in_ready), 64'(0));
            chk("bp_wdata", 64'(wdata), 64'(14));
            @(posedge clk);
            @(negedge clk);
        end
        drain();

        // Flush ten cycles into a multiply, with a competing op offered.
        send(EXE_RES_MUL, MUL_OP, 32'h1234_5678, 32'h9ABC_DEF0, 0);
        idle(9, 0);
        flush     = 1'b1;
        in_valid  = 1'b1;
        alusel    = EXE_RES_LOGIC;
        aluop     = OR_OP;
        out_ready = 1'b0;
        #1;
        chk("flush_in_ready", 64'(in_ready), 64'(0));
        q.delete();
        busy_end = 0;
        @(posedge clk);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("post_flush_in_ready", 64'(in_ready), 64'(1));
        chk("post_flush_out_valid", 64'(out_valid), 64'(0));
        @(negedge clk);
        idle(40, 0);
        send(EXE_RES_ARITH, SUB_OP, 32'h5, 32'h9, 0);
        drain();

        // Randomized mix including unknown classes/ops and back-pressure.
        for (int i = 0; i < 300; i++) begin
            send(3'($urandom_range(0, 7)), 4'($urandom_range(0, 5)), rand_opnd(), rand_opnd(), 1);
            if ($urandom_range(0, 7) == 0) idle(int'($urandom_range(1, 3)), 1);
        end
        drain();

        // XLEN=16 instance.
        run16(EXE_RES_MUL, MUL_OP, 16'h8000, 16'h0002);
        run16(EXE_RES_SHIFT, SLL_OP, 16'h0001, 16'h0013);
        run16(EXE_RES_DIV, DIV_OP, 16'h8000, 16'hFFFF);
        for (int i = 0; i < 20; i++)
            run16(3'($urandom_range(1, 5)), 4'($urandom_range(0, 3)), 16'($urandom), 16'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
